// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam int DEF_NREQ        = 4;
  localparam int DEF_GAP_TIMEOUT = 255;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin winner search: first set request at or above ptr, wrapping.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    int k;
    k      = 0;
    winner = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(ptr) + i) % NREQ;
      if (!any && req[k]) begin
        any       = 1'b1;
        idx       = IW'(k);
        winner[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter feeding one UART transmitter, with a
// mid-packet idle timeout that revokes a stalled owner.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ        = DEF_NREQ,
  parameter int GAP_TIMEOUT = DEF_GAP_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [NREQ*8-1:0] req_data_i,
  input  logic [NREQ-1:0]   req_last_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [NREQ-1:0]   gnt_o,
  output logic              tx_en_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_done_i,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam int IW = idx_w(NREQ);

  state_e          state;
  logic [IW-1:0]   ptr, owner, owner_nxt;
  logic [7:0]      gap_cnt;
  logic            last_q;
  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            hs, gap_hit, own_last;
  logic [7:0]      own_data;

  uart_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (req_valid_i),
    .ptr    (ptr),
    .winner (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign own_data  = req_data_i[8*int'(owner) +: 8];
  assign own_last  = req_last_i[owner];
  assign hs        = (state == SEND) && req_valid_i[owner];
  // This idle cycle is the GAP_TIMEOUT-th in a row: revoke now.
  assign gap_hit   = (int'(gap_cnt) + 1) >= GAP_TIMEOUT;
  assign owner_nxt = (int'(owner) == NREQ-1) ? '0 : owner + IW'(1);

  always_comb begin
    req_ready_o = '0;
    if (state == SEND) req_ready_o[owner] = req_valid_i[owner];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      gap_cnt   <= '0;
      last_q    <= 1'b0;
      tx_data_o <= '0;
      tx_en_o   <= 1'b0;
      timeout_o <= 1'b0;
      gnt_o     <= '0;
      busy_o    <= 1'b0;
    end else begin
      tx_en_o   <= 1'b0;
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_i && pick_any) begin
            owner   <= pick_idx;
            gnt_o   <= pick_oh;
            busy_o  <= 1'b1;
            gap_cnt <= '0;
            state   <= SEND;
          end
        end
        SEND: begin
          if (hs) begin
            tx_data_o <= own_data;
            last_q    <= own_last;
            tx_en_o   <= 1'b1;
            gap_cnt   <= '0;
            state     <= WAIT;
          end else if (gap_hit) begin
            timeout_o <= 1'b1;
            ptr       <= owner_nxt;
            gnt_o     <= '0;
            busy_o    <= 1'b0;
            state     <= IDLE;
          end else if (gap_cnt != 8'hFF) begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        WAIT: begin
          if (tx_done_i) begin
            if (last_q) begin
              ptr    <= owner_nxt;
              gnt_o  <= '0;
              busy_o <= 1'b0;
              state  <= IDLE;
            end else begin
              gap_cnt <= '0;
              state   <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scenarios plus a randomized run, checked every cycle against a
// packet-level reference of the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 255;

  logic           clk = 1'b0;
  logic           rst_ni, enable_i, tx_done_i;
  logic [N-1:0]   req_valid_i, req_last_i, req_ready_o, gnt_o;
  logic [N*8-1:0] req_data_i;
  logic           tx_en_o, busy_o, timeout_o;
  logic [7:0]     tx_data_o;

  uart_tx_arbiter #(.NREQ(N), .GAP_TIMEOUT(GAP)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .enable_i    (enable_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .gnt_o       (gnt_o),
    .tx_en_o     (tx_en_o),
    .tx_data_o   (tx_data_o),
    .tx_done_i   (tx_done_i),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  int checks = 0, errs = 0, cyc = 0;

  // byte sources: bit 8 = last
  logic [8:0] src_mem [N][64];
  int         src_wr[N], src_rd[N], chk_rd[N];
  logic [N-1:0] stall, hs;
  int         drop_pct;
  int         dly, done_cnt;
  logic       force_done, done_real;

  // reference: owner -1 = idle
  int         m_own, m_ptr, m_gap;
  logic       m_wait, m_last, m_txen_due, m_to_due;
  logic [7:0] m_byte;

  logic [N-1:0] log_g [64];
  logic [7:0]   log_d [64];
  int           log_c [64];
  int           dn_c  [64];
  int           nlog, ndone, to_c, t0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < N; k++) s += src_wr[k] - src_rd[k];
    return s;
  endfunction

  task automatic put(input int k, input logic [7:0] d, input logic l);
    src_mem[k][src_wr[k] & 63] = {l, d};
    src_wr[k]++;
  endtask

  task automatic load(input int k, input int n);
    for (int i = 0; i < n; i++) put(k, 8'($urandom), (i == n - 1));
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      logic [8:0] w;
      w = src_mem[k][src_rd[k] & 63];
      req_valid_i[k] = (src_rd[k] < src_wr[k]) && !stall[k] &&
                       (int'($urandom_range(99)) >= drop_pct);
      req_data_i[8*k +: 8] = w[7:0];
      req_last_i[k] = w[8];
    end
  endtask

  task automatic model_step();
    logic [N-1:0] e_gnt, e_rdy;
    e_gnt = '0;
    e_rdy = '0;
    if (m_own >= 0) begin
      e_gnt[m_own] = 1'b1;
      if (!m_wait && req_valid_i[m_own]) e_rdy = e_gnt;
    end
    chk("gnt", 32'(gnt_o), 32'(e_gnt));
    chk("busy", 32'(busy_o), 32'(m_own >= 0));
    chk("ready", 32'(req_ready_o), 32'(e_rdy));
    chk("tx_en", 32'(tx_en_o), 32'(m_txen_due));
    chk("timeout", 32'(timeout_o), 32'(m_to_due));
    if (m_wait) chk("tx_data", 32'(tx_data_o), 32'(m_byte));
    if (tx_en_o) begin
      if (nlog < 64) begin log_g[nlog] = gnt_o; log_d[nlog] = tx_data_o; log_c[nlog] = cyc; end
      nlog++;
    end
    if (timeout_o) to_c = cyc;
    if (done_real) begin
      if (ndone < 64) dn_c[ndone] = cyc;
      ndone++;
    end
    m_txen_due = 1'b0;
    m_to_due   = 1'b0;
    if (m_own < 0) begin
      if (enable_i && req_valid_i != '0) begin
        m_own = rr(req_valid_i, m_ptr); m_wait = 1'b0; m_gap = 0;
      end
    end else if (!m_wait) begin
      if (req_valid_i[m_own]) begin
        {m_last, m_byte} = src_mem[m_own][chk_rd[m_own] & 63];
        chk_rd[m_own]++;
        m_wait = 1'b1; m_txen_due = 1'b1;
      end else begin
        m_gap++;
        if (m_gap >= GAP) begin m_to_due = 1'b1; m_ptr = (m_own + 1) % N; m_own = -1; end
      end
    end else if (tx_done_i) begin
      m_wait = 1'b0;
      m_gap  = 0;
      if (m_last) begin m_ptr = (m_own + 1) % N; m_own = -1; end
    end
  endtask

  task automatic tick();
    drive();
    @(negedge clk);
    if (!rst_ni)
      chk("rst_outs", 32'({gnt_o, busy_o, tx_en_o, timeout_o, req_ready_o, tx_data_o}), 32'(0));
    else
      model_step();
    hs = req_valid_i & req_ready_o;
    if (tx_en_o) done_cnt = dly;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < N; k++) if (hs[k]) src_rd[k]++;
    tx_done_i = 1'b0;
    done_real = 1'b0;
    if (force_done) begin tx_done_i = 1'b1; force_done = 1'b0; end
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin tx_done_i = 1'b1; done_real = 1'b1; end
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; tx_done_i = 1'b0; force_done = 1'b0; done_real = 1'b0;
    done_cnt = 0; stall = '0; drop_pct = 0;
    for (int k = 0; k < N; k++) begin src_wr[k] = 0; src_rd[k] = 0; chk_rd[k] = 0; end
    m_own = -1; m_ptr = 0; m_gap = 0; m_wait = 1'b0; m_last = 1'b0;
    m_txen_due = 1'b0; m_to_due = 1'b0; m_byte = '0;
    nlog = 0; ndone = 0; to_c = -1;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic drain(input string tag, input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      tick();
      if (pending() == 0 && gnt_o == '0 && done_cnt == 0) break;
    end
    chk(tag, 32'(i < bound), 32'(1));
  endtask

  task automatic wait_log(input string tag, input int n, input int bound);
    for (int i = 0; i < bound && nlog < n; i++) tick();
    chk(tag, 32'(nlog >= n), 32'(1));
  endtask

  initial begin
    rst_ni = 1'b0; enable_i = 1'b1; req_valid_i = '0; req_data_i = '0;
    req_last_i = '0; tx_done_i = 1'b0; dly = 10; stall = '0;
    do_reset();

    // single requester, two-byte packet, then ptr=2 shows via next order
    put(1, 8'h55, 1'b0); put(1, 8'hA3, 1'b1);
    drain("t1_drain", 200);
    chk("t1_nbytes", 32'(nlog), 32'(2));
    chk("t1_byte0", 32'(log_d[0]), 32'h55);
    chk("t1_byte1", 32'(log_d[1]), 32'hA3);
    chk("t1_gnt0", 32'(log_g[0]), 32'b0010);
    chk("t1_gnt1", 32'(log_g[1]), 32'b0010);
    put(0, 8'h10, 1'b1); put(3, 8'h13, 1'b1);
    drain("t1b_drain", 200);
    chk("t1_ptr_first", 32'(log_g[2]), 32'b1000);
    chk("t1_ptr_second", 32'(log_g[3]), 32'b0001);

    // all four at once from reset: order and latency
    do_reset(); dly = 4;
    for (int k = 0; k < N; k++) put(k, 8'(8'h20 + k), 1'b1);
    t0 = cyc;
    drain("t2_drain", 200);
    for (int k = 0; k < N; k++) begin
      int e;
      e = (k == 0) ? t0 + 2 : 0;
      if (k > 0) e = dn_c[k-1] + 3;
      chk("t2_order", 32'(log_g[k]), 32'(1 << k));
      chk("t2_latency", 32'(log_c[k]), 32'(e));
    end

    // atomic 3-byte packet from 2 while 0 waits
    do_reset(); dly = 5;
    put(2, 8'hB1, 1'b0); put(2, 8'hB2, 1'b0); put(2, 8'hB3, 1'b1);
    tick(); tick();
    put(0, 8'h77, 1'b1);
    drain("t3_drain", 300);
    for (int i = 0; i < 3; i++) chk("t3_owner2", 32'(log_g[i]), 32'b0100);
    chk("t3_then0", 32'(log_g[3]), 32'b0001);
    chk("t3_after_done", 32'(log_c[3]), 32'(dn_c[2] + 3));

    // owner 3 stalls mid-packet until revoked
    do_reset(); dly = 10;
    put(3, 8'h31, 1'b0); put(3, 8'h32, 1'b1);
    wait_log("t4_first_byte", 1, 50);
    stall[3] = 1'b1;
    put(0, 8'h01, 1'b1);
    for (int i = 0; i < 400 && to_c < 0; i++) tick();
    chk("t4_timeout_seen", 32'(to_c >= 0), 32'(1));
    chk("t4_timeout_cycle", 32'(to_c), 32'(dn_c[0] + 256));
    stall[3] = 1'b0;
    drain("t4_drain", 200);
    chk("t4_next_owner", 32'(log_g[1]), 32'b0001);
    chk("t4_resume3", 32'(log_g[2]), 32'b1000);

    // asynchronous reset while waiting for tx_done
    do_reset(); dly = 10;
    put(1, 8'hC1, 1'b0); put(1, 8'hC2, 1'b1);
    wait_log("t5_first_byte", 1, 50);
    tick(); tick();
    #2 rst_ni = 1'b0;
    #1 chk("t5_async_zero", 32'({gnt_o, busy_o, tx_en_o, timeout_o, req_ready_o, tx_data_o}), 32'(0));
    do_reset();
    force_done = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("t5_no_tx", 32'(nlog), 32'(0));
    put(3, 8'hD3, 1'b1); put(0, 8'hD0, 1'b1);
    drain("t5_drain", 200);
    chk("t5_fresh_from0", 32'(log_g[0]), 32'b0001);

    // enable dropped during byte 1 of 2
    do_reset(); dly = 6;
    put(2, 8'hE1, 1'b0); put(2, 8'hE2, 1'b1);
    wait_log("t6_first_byte", 1, 50);
    enable_i = 1'b0;
    put(0, 8'h0A, 1'b1); put(1, 8'h1A, 1'b1);
    for (int i = 0; i < 40; i++) tick();
    chk("t6_nbytes", 32'(nlog), 32'(2));
    chk("t6_byte2", 32'(log_d[1]), 32'hE2);
    chk("t6_held_idle", 32'({gnt_o, busy_o}), 32'(0));
    enable_i = 1'b1;
    drain("t6_drain", 200);
    chk("t6_resume0", 32'(log_g[2]), 32'b0001);
    chk("t6_resume1", 32'(log_g[3]), 32'b0010);

    // randomized traffic
    do_reset(); drop_pct = 25;
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(9) == 0) begin
        int k;
        k = int'($urandom_range(N - 1));
        if (src_wr[k] < 56) load(k, int'($urandom_range(4, 1)));
      end
      enable_i = ($urandom_range(19) != 0);
      dly = int'($urandom_range(6, 1));
      tick();
    end
    enable_i = 1'b1; drop_pct = 0;
    drain("t7_drain", 3000);
    for (int k = 0; k < N; k++) chk("t7_consumed", 32'(chk_rd[k]), 32'(src_wr[k]));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
